// File: rtl/jt1943_obj_pkg.sv
// Shared definitions for the per-line object scanner and its line buffer.
// Contents: geometry localparams, slot byte offsets, blank marker, scan FSM
// encoding, buffer write-port payload and the vertical zone check.
package jt1943_obj_pkg;

    localparam int unsigned OBJ_N  = 128;
    localparam int unsigned SLOTS  = 32;
    localparam int unsigned AW     = 9;
    localparam int unsigned OBJW   = 7;
    localparam int unsigned SLOTW  = 5;
    localparam int unsigned FOUNDW = 6;

    // Byte 2 of an empty slot: a y value that can never be in zone
    localparam logic [7:0] BLANK_Y = 8'hF8;

    localparam logic [1:0] CODE_LO = 2'd0;
    localparam logic [1:0] ATTR    = 2'd1;
    localparam logic [1:0] YPOS    = 2'd2;
    localparam logic [1:0] XPOS    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_Y   = 3'd1,
        ST_WAIT_Y = 3'd2,
        ST_RD_B   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } scan_state_t;

    // One write into the line list being built
    typedef struct packed {
        logic             we;
        logic             set_vld;
        logic [SLOTW-1:0] slot;
        logic [1:0]       bsel;
        logic [7:0]       data;
    } obj_wr_t;

    // 16-line window starting two lines above y; a window whose end wraps
    // past 255 is treated as off screen, exactly as the drawer does
    function automatic logic in_zone(input logic [7:0] v, input logic [7:0] y);
        logic [7:0] ys;
        logic [7:0] ye;
        ys = y - 8'd2;
        ye = ys + 8'd16;
        return (ye > ys) && (v >= ys) && (v < ye);
    endfunction

endpackage

// File: rtl/jt1943_objscan_buf.sv
// Ping-pong object line buffer: two banks of SLOTS x 4 bytes with a valid bit
// per slot. The scanner writes bank wr_bank; the drawer reads bank ~wr_bank.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears valid bits and read data)
//   wr_bank     bank currently owned by the scanner
//   clr         clear valid bits of ~wr_bank (the bank about to be written)
//   wport       write payload (byte write, optional valid set)
//   rd_slot     drawer slot index
//   rd_byte     drawer byte select
//   rd_data     registered read data, blank values for invalid slots
module jt1943_objscan_buf
    import jt1943_obj_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_bank,
    input  logic             clr,
    input  obj_wr_t          wport,
    input  logic [SLOTW-1:0] rd_slot,
    input  logic [1:0]       rd_byte,
    output logic [7:0]       rd_data
);

    localparam int unsigned DEPTH = 2 * SLOTS * 4;

    logic [7:0]            mem [DEPTH];
    logic [1:0][SLOTS-1:0] vld;
    logic                  rd_bank_c;
    logic [7:0]            blank_c;

    assign rd_bank_c = ~wr_bank;
    assign blank_c   = (rd_byte == YPOS) ? BLANK_Y : 8'h00;

    // Byte storage, no reset needed: only reachable through a valid bit
    always_ff @(posedge clk) begin
        if (wport.we) begin
            mem[{wr_bank, wport.slot, wport.bsel}] <= wport.data;
        end
    end

    // Valid bits; clr targets the bank that becomes the write bank after the swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            if (wport.set_vld) begin
                vld[wr_bank][wport.slot] <= 1'b1;
            end
            if (clr) begin
                vld[rd_bank_c] <= '0;
            end
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= vld[rd_bank_c][rd_slot] ? mem[{rd_bank_c, rd_slot, rd_byte}] : blank_c;
        end
    end

endmodule

// File: rtl/jt1943_objscan.sv
// Per-line sprite scanner. While line N is displayed it walks object RAM,
// picks the objects in vertical zone for line V and packs them into the
// write bank of a ping-pong line list; the drawer reads the other bank.
// Optional feature: define JT1943_OBJSCAN_OVF_EN to get obj_ovf, set when an
// in-zone object finds the list already full (cleared at HINIT).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   HINIT        line start pulse: swap banks, restart scan
//   V            line the list is built for
//   objram_addr  object RAM address {obj, byte}
//   objram_data  object RAM data, one clock after the address
//   objcnt       drawer slot index
//   pxlcnt       drawer pixel count, [1:0] selects the byte
//   objbuf_data  registered slot byte for the drawer
//   obj_ovf      list overflow flag (0 unless the macro is defined)
module jt1943_objscan
    import jt1943_obj_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          HINIT,
    input  logic [7:0]    V,
    output logic [AW-1:0] objram_addr,
    input  logic [7:0]    objram_data,
    input  logic [4:0]    objcnt,
    input  logic [3:0]    pxlcnt,
    output logic [7:0]    objbuf_data,
    output logic          obj_ovf
);

    scan_state_t       state, state_nxt;
    logic [OBJW-1:0]   obj, obj_nxt;
    logic [FOUNDW-1:0] found, found_nxt;
    logic [2:0]        bcnt, bcnt_nxt;
    logic [7:0]        y_lat, y_nxt;
    logic              wr, wr_nxt;
    logic [AW-1:0]     addr_nxt;
    obj_wr_t           wport_c;
    logic              last_obj_c;
    logic              full_c;
    logic              zone_c;
    logic              unused_pxl_c;

    assign last_obj_c   = (obj == OBJW'(OBJ_N - 1));
    assign full_c       = (found == FOUNDW'(SLOTS));
    assign zone_c       = in_zone(V, objram_data);
    assign unused_pxl_c = ^pxlcnt[3:2];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; HINIT restarts the scan from any state
    always_comb begin
        state_nxt = state;
        if (HINIT) begin
            state_nxt = ST_RD_Y;
        end else begin
            case (state)
                ST_RD_Y:   state_nxt = ST_WAIT_Y;
                ST_WAIT_Y: begin
                    if (zone_c && full_c) begin
                        state_nxt = ST_DONE;
                    end else if (zone_c) begin
                        state_nxt = ST_RD_B;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end
                ST_RD_B:   if (bcnt == 3'd4) state_nxt = ST_NEXT;
`ifdef JT1943_OBJSCAN_OVF_EN
                // Keep scanning after the list fills so an overflow can be seen
                ST_NEXT:   state_nxt = last_obj_c ? ST_DONE : ST_RD_Y;
`else
                ST_NEXT:   state_nxt = (last_obj_c || full_c) ? ST_DONE : ST_RD_Y;
`endif
                default:   state_nxt = state;
            endcase
        end
    end

    // Datapath and buffer writes. The RAM address is loaded on entry to each
    // read state so the returned byte is ready in the following state.
    always_comb begin
        obj_nxt   = obj;
        found_nxt = found;
        bcnt_nxt  = bcnt;
        y_nxt     = y_lat;
        wr_nxt    = wr;
        addr_nxt  = objram_addr;
        wport_c   = '0;
        if (HINIT) begin
            wr_nxt    = ~wr;
            found_nxt = FOUNDW'(1);
            obj_nxt   = '0;
            bcnt_nxt  = '0;
            addr_nxt  = {OBJW'(0), YPOS};
        end else begin
            case (state)
                ST_WAIT_Y: begin
                    if (zone_c && !full_c) begin
                        y_nxt    = objram_data;
                        bcnt_nxt = '0;
                        addr_nxt = {obj, CODE_LO};
                    end
                end
                ST_RD_B: begin
                    bcnt_nxt     = bcnt + 3'd1;
                    wport_c.slot = found[SLOTW-1:0];
                    case (bcnt)
                        3'd0: addr_nxt = {obj, ATTR};
                        3'd1: begin
                            addr_nxt     = {obj, XPOS};
                            wport_c.we   = 1'b1;
                            wport_c.bsel = CODE_LO;
                            wport_c.data = objram_data;
                        end
                        3'd2: begin
                            wport_c.we   = 1'b1;
                            wport_c.bsel = ATTR;
                            wport_c.data = objram_data;
                        end
                        3'd3: begin
                            wport_c.we   = 1'b1;
                            wport_c.bsel = XPOS;
                            wport_c.data = objram_data;
                        end
                        3'd4: begin
                            // y was latched at the zone check, so the slot completes here
                            wport_c.we      = 1'b1;
                            wport_c.set_vld = 1'b1;
                            wport_c.bsel    = YPOS;
                            wport_c.data    = y_lat;
                            found_nxt       = found + FOUNDW'(1);
                        end
                        default: ;
                    endcase
                end
                ST_NEXT: begin
                    if (state_nxt == ST_RD_Y) begin
                        obj_nxt  = obj + OBJW'(1);
                        addr_nxt = {obj + OBJW'(1), YPOS};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj         <= '0;
            found       <= '0;
            bcnt        <= '0;
            y_lat       <= '0;
            wr          <= 1'b0;
            objram_addr <= '0;
        end else begin
            obj         <= obj_nxt;
            found       <= found_nxt;
            bcnt        <= bcnt_nxt;
            y_lat       <= y_nxt;
            wr          <= wr_nxt;
            objram_addr <= addr_nxt;
        end
    end

`ifdef JT1943_OBJSCAN_OVF_EN
    logic ovf, ovf_nxt;

    always_comb begin
        ovf_nxt = ovf;
        if (HINIT) begin
            ovf_nxt = 1'b0;
        end else if (state == ST_WAIT_Y && zone_c && full_c) begin
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_nxt;
        end
    end

    assign obj_ovf = ovf;
`else
    assign obj_ovf = 1'b0;
`endif

    jt1943_objscan_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_bank (wr),
        .clr     (HINIT),
        .wport   (wport_c),
        .rd_slot (objcnt),
        .rd_byte (pxlcnt[1:0]),
        .rd_data (objbuf_data)
    );

endmodule

// File: tb/tb_jt1943_objscan.sv
`timescale 1ns/1ps
module tb_jt1943_objscan;

    logic       clk;
    logic       rst_n;
    logic       hinit;
    logic [7:0] v;
    logic [8:0] objram_addr;
    logic [7:0] objram_data;
    logic [4:0] objcnt;
    logic [3:0] pxlcnt;
    logic [7:0] objbuf_data;
    logic       obj_ovf;

    logic [7:0] oram [512];
    logic [7:0] exp_b [32][4];
    logic       exp_ovf;

    int n_checks = 0;
    int n_errors = 0;

    jt1943_objscan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .HINIT       (hinit),
        .V           (v),
        .objram_addr (objram_addr),
        .objram_data (objram_data),
        .objcnt      (objcnt),
        .pxlcnt      (pxlcnt),
        .objbuf_data (objbuf_data),
        .obj_ovf     (obj_ovf)
    );

    initial clk = 1'b0;
    always #21 clk = ~clk;

    // Object RAM: synchronous read, data one clock after the address
    always @(posedge clk) objram_data <= oram[objram_addr];

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference list: objects in ascending order, window [y-2, y+14) with
    // windows crossing 255 dropped; first maxn hits go to slots 1..maxn
    task automatic build_expected(input logic [7:0] vv, input int maxn);
        int n;
        int ys;
        n = 0;
        exp_ovf = 1'b0;
        for (int s = 0; s < 32; s++) begin
            exp_b[s][0] = 8'h00;
            exp_b[s][1] = 8'h00;
            exp_b[s][2] = 8'hF8;
            exp_b[s][3] = 8'h00;
        end
        for (int o = 0; o < 128; o++) begin
            ys = (int'(oram[o*4+2]) + 254) % 256;
            if ((ys + 16 < 256) && (int'(vv) >= ys) && (int'(vv) < ys + 16)) begin
                if (n < maxn) begin
                    n++;
                    for (int b = 0; b < 4; b++) exp_b[n][b] = oram[o*4+b];
                end else if (n >= 31) begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_oram();
        for (int o = 0; o < 128; o++) begin
            oram[o*4+0] = 8'($urandom);
            oram[o*4+1] = 8'($urandom);
            oram[o*4+2] = 8'h00;
            oram[o*4+3] = 8'($urandom);
        end
    endtask

    task automatic fill_random(input int pct, input logic [7:0] vv);
        for (int o = 0; o < 128; o++) begin
            oram[o*4+0] = 8'($urandom);
            oram[o*4+1] = 8'($urandom);
            oram[o*4+3] = 8'($urandom);
            if (int'($urandom_range(0, 99)) < pct)
                oram[o*4+2] = 8'(int'(vv) + 2 - int'($urandom_range(0, 17)));
            else
                oram[o*4+2] = 8'($urandom);
        end
    endtask

    // Called at a negedge; HINIT is seen by exactly one rising edge
    task automatic hinit_pulse();
        hinit = 1'b1;
        @(negedge clk);
        hinit = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int s = 0; s < 32; s++) begin
            for (int b = 0; b < 4; b++) begin
                objcnt = 5'(s);
                pxlcnt = {2'($urandom), 2'(b)};
                @(negedge clk);
                chk($sformatf("%s s%0d b%0d", tag, s, b), 16'(objbuf_data), 16'(exp_b[s][b]));
            end
        end
    endtask

    task automatic run_round(input logic [7:0] vv, input string tag);
        logic want_ovf;
        v = vv;
        build_expected(vv, 31);
`ifdef JT1943_OBJSCAN_OVF_EN
        want_ovf = exp_ovf;
`else
        want_ovf = 1'b0;
`endif
        hinit_pulse();
        chk({tag, " start_addr"}, 16'(objram_addr), 16'h0002);
        repeat (1100) @(negedge clk);
        chk({tag, " ovf"}, 16'(obj_ovf), 16'(want_ovf));
        hinit_pulse();
        chk({tag, " restart_addr"}, 16'(objram_addr), 16'h0002);
        chk({tag, " ovf_clr"}, 16'(obj_ovf), 16'h0000);
        read_all(tag);
    endtask

    initial begin
        int pcts [6];
        pcts = '{5, 20, 50, 100, 30, 10};
        rst_n  = 1'b0;
        hinit  = 1'b0;
        v      = 8'h00;
        objcnt = 5'd0;
        pxlcnt = 4'd0;
        for (int i = 0; i < 512; i++) oram[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst objbuf", 16'(objbuf_data), 16'h0000);
        chk("rst addr", 16'(objram_addr), 16'h0000);
        chk("rst ovf", 16'(obj_ovf), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // single object in zone, then same RAM with the line above the window
        clear_oram();
        oram[0] = 8'h5A; oram[1] = 8'hC3; oram[2] = 8'h42; oram[3] = 8'h77;
        run_round(8'h45, "t1");
        run_round(8'h3F, "t2");

        // more in-zone objects than slots
        clear_oram();
        for (int o = 0; o < 40; o++) oram[o*4+2] = 8'h22;
        run_round(8'h25, "t3");

        // line restart after five objects completed
        clear_oram();
        for (int o = 0; o < 10; o++) oram[o*4+2] = 8'h22;
        v = 8'h25;
        build_expected(8'h25, 5);
        hinit_pulse();
        repeat (42) @(negedge clk);
        hinit_pulse();
        chk("t4 restart_addr", 16'(objram_addr), 16'h0002);
        read_all("t4");

        // reset in the middle of copying an object
        clear_oram();
        oram[0] = 8'hA5; oram[1] = 8'h3C; oram[2] = 8'h42; oram[3] = 8'h11;
        run_round(8'h45, "t5pre");
        objcnt = 5'd1;
        pxlcnt = 4'd0;
        hinit_pulse();
        repeat (2) @(negedge clk);
        chk("t5 before_rst", 16'(objbuf_data), 16'h00A5);
        rst_n = 1'b0;
        #1;
        chk("t5 rst objbuf", 16'(objbuf_data), 16'h0000);
        chk("t5 rst addr", 16'(objram_addr), 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5 idle addr", 16'(objram_addr), 16'h0000);
        chk("t5 blank b0", 16'(objbuf_data), 16'h0000);
        pxlcnt = 4'd2;
        @(negedge clk);
        chk("t5 blank b2", 16'(objbuf_data), 16'h00F8);
        run_round(8'h45, "t5post");

        // window wrapping past 255
        clear_oram();
        oram[2] = 8'h01;
        run_round(8'h05, "t6");

        // window edges: first line, last line, one past each end
        clear_oram();
        oram[0*4+2] = 8'h82;
        oram[1*4+2] = 8'h73;
        oram[2*4+2] = 8'h72;
        oram[3*4+2] = 8'h83;
        run_round(8'h80, "tedge");

        for (int r = 0; r < 6; r++) begin
            logic [7:0] rv;
            rv = (r == 5) ? 8'hF5 : 8'($urandom);
            fill_random(pcts[r], rv);
            run_round(rv, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
